lcd_bus_scheduler: RTL and testbench
====================================

Name: lcd_bus_scheduler

Overview:
- Shares the single HD44780-style 8-bit LCD bus among N_REQ requesters, e.g. the pet-face writer, the status-icon writer and the text writer.
- Requesters submit command/data bytes over valid/ready with a burst "last" flag.
- A round-robin arbiter grants one requester per burst.
- A timing engine turns each byte into a correctly timed enable pulse and waits the controller execution time, so the requesters never handle LCD timing themselves.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- POWERUP_CYC, 1000000, cycles held off after reset before the first byte (20 ms at 50 MHz).
- TAS_CYC, 2, rs/data setup cycles before lcd_enable rises.
- EN_HIGH_CYC, 25, lcd_enable high width in cycles.
- TH_CYC, 2, rs/data hold cycles after lcd_enable falls.
- SHORT_WAIT_CYC, 2000, execution wait for ordinary commands and data (40 us).
- LONG_WAIT_CYC, 80000, execution wait for clear-display and return-home (1.6 ms).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_rs  in  N_REQ  per-requester register select (0 = command, 1 = data).
- req_data  in  8*N_REQ  per-requester byte; requester i occupies [8i+7:8i].
- req_last  in  N_REQ  marks the final byte of a burst.
- req_ready  out  N_REQ  byte accepted this cycle.
- lcd_rs  out  1  LCD register select.
- lcd_rw  out  1  LCD read/write; tied 0 (write only).
- lcd_enable  out  1  LCD E strobe.
- lcd_data  out  8  LCD data bus.
- grant_id  out  $clog2(N_REQ)  current or last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (asserted immediately and asynchronously on reset=0, including mid-pulse):
  - lcd_enable=0, lcd_rs=0, lcd_rw=0, lcd_data=0x00, req_ready=0.
  - grant_id=0, busy=1, lock=0, rr pointer=N_REQ-1 (so requester 0 wins first).
  - state=POWERUP, all counters 0.
- State machine: POWERUP, IDLE, SETUP, PULSE, HOLD, WAIT.
- POWERUP: counts POWERUP_CYC cycles, then goes to IDLE. No req_ready is asserted during POWERUP.
- IDLE arbitration (combinational):
  - If lock=0, the winner is the first index with req_valid set, searching from pointer+1 modulo N_REQ.
  - If lock=1, the winner is the locked grant_id only; other requesters are ignored even when valid.
- Acceptance: req_ready[w]=1 only when state==IDLE and req_valid[w]=1 for the winner w. At most one bit of req_ready is high; it is high for one cycle per byte.
- On acceptance, in the same edge:
  - Latch rs and data into lcd_rs and lcd_data; set grant_id=w.
  - If req_last[w]=0: set lock=1.
  - If req_last[w]=1: set lock=0 and pointer=w.
  - Go to SETUP.
- SETUP lasts TAS_CYC cycles with lcd_enable=0.
- PULSE lasts EN_HIGH_CYC cycles with lcd_enable=1. lcd_enable is registered and glitch-free.
- HOLD lasts TH_CYC cycles with lcd_enable=0; lcd_rs and lcd_data are stable throughout.
- WAIT lasts LONG_WAIT_CYC if the latched rs=0 and data is 0x01, 0x02 or 0x03; otherwise SHORT_WAIT_CYC. WAIT then returns to IDLE.
- Latency: lcd_enable rises exactly TAS_CYC+1 cycles after the acceptance edge. Minimum byte period is 1+TAS_CYC+EN_HIGH_CYC+TH_CYC+wait cycles.
- lcd_rs and lcd_data change only on acceptance edges and hold their value until the next acceptance.
- Locked requester drops valid mid-burst: the grant is held indefinitely and there is no timeout. Other requesters starve by design; requesters must complete bursts.
- Simultaneous valids with lock=0: round-robin order is strict. A requester is served at most once per rotation of single-byte bursts.
- Each phase counter counts 0..len-1. Counter width is $clog2 of the largest phase length. A phase length of 1 is legal; 0 is illegal and is checked by an assertion.

Decomposition:
- Package lcd_pkg holds:
  - state enum.
  - CMD_CLEAR_DISPLAY=0x01, CMD_RETURN_HOME=0x02.
  - is_long_cmd() helper.
  - Default timing constants shared with the existing LCD writers.
- Sub-module lcd_rr_arbiter (pure round-robin with lock input, pointer register and one-hot/index grant outputs) is natural. The timing FSM stays in lcd_bus_scheduler.

Test Plan (sim parameters POWERUP=10, TAS=2, EN_HIGH=4, TH=2, SHORT=8, LONG=30, N_REQ=3):
- Reset release with req_valid=3'b111 -> no req_ready before cycle 10; the first grant goes to requester 0; lcd_enable rises 3 cycles after acceptance and stays high 4 cycles.
- Requester 1 sends burst {rs=0 0x40, rs=1 0x1F, rs=1 0x0E last} while requester 2 is valid throughout -> 3 consecutive grants to 1, then requester 2 is granted; lcd_data shows 0x40, 0x1F, 0x0E in order with lcd_rs 0,1,1.
- rs=0 0x01 from requester 0 -> WAIT lasts 30 cycles; rs=1 0x01 -> WAIT lasts 8 cycles.
- All three requesters issue single-byte last bursts continuously -> grant order 0,1,2,0,1,2; no requester is granted twice in a row.
- Reset asserted during PULSE -> lcd_enable=0 in the same cycle (asynchronous); after release, POWERUP repeats and grant restarts at requester 0.
- Locked requester 2 deasserts valid mid-burst for 50 cycles while requester 0 is valid -> req_ready[0] stays 0; the burst resumes with requester 2 when it reasserts.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, command codes and default timing for the HD44780 bus writers.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } state_t;

  localparam logic [7:0] CMD_CLEAR_DISPLAY = 8'h01;
  localparam logic [7:0] CMD_RETURN_HOME   = 8'h02;
  localparam logic [7:0] CMD_RETURN_HOME_X = 8'h03;

  // 50 MHz defaults
  localparam int unsigned DEF_POWERUP_CYC    = 1000000;
  localparam int unsigned DEF_TAS_CYC        = 2;
  localparam int unsigned DEF_EN_HIGH_CYC    = 25;
  localparam int unsigned DEF_TH_CYC         = 2;
  localparam int unsigned DEF_SHORT_WAIT_CYC = 2000;
  localparam int unsigned DEF_LONG_WAIT_CYC  = 80000;

  // Clear-display and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == CMD_CLEAR_DISPLAY || data == CMD_RETURN_HOME ||
                   data == CMD_RETURN_HOME_X);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Round-robin arbiter with burst lock; pointer holds the last requester that finished a burst.
module lcd_rr_arbiter #(
  parameter  int N_REQ = 3,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             lock,
  input  logic [IW-1:0]    lock_id,
  input  logic             update,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [IW-1:0]    gnt_idx,
  output logic             gnt_any
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Scan downward so the candidate closest after ptr is the last one written.
  always_comb begin
    gnt_idx = lock_id;
    gnt_any = 1'b0;
    cand    = '0;
    if (lock) begin
      gnt_any = req[lock_id];
    end else begin
      for (int k = N_REQ; k >= 1; k--) begin
        cand = IW'((int'(ptr) + k) % N_REQ);
        if (req[cand]) begin
          gnt_idx = cand;
          gnt_any = 1'b1;
        end
      end
    end
  end

  assign gnt_oh = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      ptr <= IW'(N_REQ - 1);
    else if (update) ptr <= gnt_idx;
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares one HD44780 8-bit write bus among N_REQ requesters and owns all bus timing.
module lcd_bus_scheduler
  import lcd_pkg::*;
#(
  parameter  int unsigned N_REQ          = 3,
  parameter  int unsigned POWERUP_CYC    = DEF_POWERUP_CYC,
  parameter  int unsigned TAS_CYC        = DEF_TAS_CYC,
  parameter  int unsigned EN_HIGH_CYC    = DEF_EN_HIGH_CYC,
  parameter  int unsigned TH_CYC         = DEF_TH_CYC,
  parameter  int unsigned SHORT_WAIT_CYC = DEF_SHORT_WAIT_CYC,
  parameter  int unsigned LONG_WAIT_CYC  = DEF_LONG_WAIT_CYC,
  localparam int          IW             = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_rs,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic               lcd_rs,
  output logic               lcd_rw,
  output logic               lcd_enable,
  output logic [7:0]         lcd_data,
  output logic [IW-1:0]      grant_id,
  output logic               busy
);

  localparam int unsigned MAXL = max2(max2(max2(POWERUP_CYC, TAS_CYC), max2(EN_HIGH_CYC, TH_CYC)),
                                      max2(SHORT_WAIT_CYC, LONG_WAIT_CYC));
  localparam int CW = (MAXL > 1) ? $clog2(MAXL) : 1;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, last_cnt;
  logic                   phase_done, lock, accept;
  logic [N_REQ-1:0][7:0]  data_arr;
  logic [N_REQ-1:0]       gnt_oh;
  logic [IW-1:0]          gnt_idx;
  logic                   gnt_any;

  assign data_arr = req_data;

  lcd_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .lock    (lock),
    .lock_id (grant_id),
    .update  (accept && req_last[gnt_idx]),
    .gnt_oh  (gnt_oh),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign accept    = (state == ST_IDLE) && gnt_any;
  assign req_ready = accept ? gnt_oh : '0;
  assign busy      = (state != ST_IDLE);
  assign lcd_rw    = 1'b0;

  // Wait length keys off the latched byte, which is stable until the next acceptance.
  always_comb begin
    last_cnt = '0;
    case (state)
      ST_POWERUP: last_cnt = CW'(POWERUP_CYC - 1);
      ST_SETUP:   last_cnt = CW'(TAS_CYC - 1);
      ST_PULSE:   last_cnt = CW'(EN_HIGH_CYC - 1);
      ST_HOLD:    last_cnt = CW'(TH_CYC - 1);
      ST_WAIT:    last_cnt = is_long_cmd(lcd_rs, lcd_data) ? CW'(LONG_WAIT_CYC - 1)
                                                            : CW'(SHORT_WAIT_CYC - 1);
      default:    last_cnt = '0;
    endcase
  end

  assign phase_done = (cnt == last_cnt);

  always_comb begin
    state_nx = state;
    case (state)
      ST_POWERUP: if (phase_done) state_nx = ST_IDLE;
      ST_IDLE:    if (accept)     state_nx = ST_SETUP;
      ST_SETUP:   if (phase_done) state_nx = ST_PULSE;
      ST_PULSE:   if (phase_done) state_nx = ST_HOLD;
      ST_HOLD:    if (phase_done) state_nx = ST_WAIT;
      ST_WAIT:    if (phase_done) state_nx = ST_IDLE;
      default:    state_nx = ST_POWERUP;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_POWERUP;
    else        state <= state_nx;
  end

  // Enable is registered from the next state so it rises with the first PULSE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      lock       <= 1'b0;
      grant_id   <= '0;
      lcd_rs     <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_enable <= 1'b0;
    end else begin
      cnt        <= (state_nx != state || state == ST_IDLE) ? '0 : cnt + 1'b1;
      lcd_enable <= (state_nx == ST_PULSE);
      if (accept) begin
        lcd_rs   <= req_rs[gnt_idx];
        lcd_data <= data_arr[gnt_idx];
        grant_id <= gnt_idx;
        lock     <= !req_last[gnt_idx];
      end
    end
  end

  always_ff @(posedge clk)
    assert (POWERUP_CYC > 0 && TAS_CYC > 0 && EN_HIGH_CYC > 0 && TH_CYC > 0 &&
            SHORT_WAIT_CYC > 0 && LONG_WAIT_CYC > 0);

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Randomized bench for lcd_bus_scheduler against a timeline-based reference model.
module tb_lcd_bus_scheduler;

  localparam int N = 3, PWR = 10, TAS = 2, EN = 4, TH = 2, SHORT = 8, LONG = 30;

  logic           clk, reset;
  logic [N-1:0]   req_valid, req_rs, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           lcd_rs, lcd_rw, lcd_enable, busy;
  logic [7:0]     lcd_data;
  logic [1:0]     grant_id;

  lcd_bus_scheduler #(
    .N_REQ(N), .POWERUP_CYC(PWR), .TAS_CYC(TAS), .EN_HIGH_CYC(EN), .TH_CYC(TH),
    .SHORT_WAIT_CYC(SHORT), .LONG_WAIT_CYC(LONG)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rs(req_rs), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_enable(lcd_enable), .lcd_data(lcd_data), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // requester byte queues: {last, rs, data}
  logic [9:0] fifo [N][256];
  int         hd [N];
  int         tl [N];
  logic [N-1:0] en;

  // reference model: powerup countdown plus position within the current byte timeline
  int m_pwr, m_t, m_ptr, m_gid;
  logic m_lock, m_rs;
  logic [7:0] m_data;

  int acc_cyc[$], acc_id[$], rise_cyc[$], wid_q[$], dlog[$];
  int rdy0_cnt, rise_at;
  logic prev_en, prev_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int wait_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? LONG : SHORT;
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic all_empty();
    for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_pwr = PWR; m_t = 0; m_ptr = N - 1; m_gid = 0;
    m_lock = 1'b0; m_rs = 1'b0; m_data = 8'h00;
  endtask

  task automatic clear_logs();
    acc_cyc.delete(); acc_id.delete(); rise_cyc.delete(); wid_q.delete(); dlog.delete();
    prev_acc = 1'b0;
  endtask

  task automatic drive_inputs();
    logic [9:0] e;
    for (int i = 0; i < N; i++) begin
      e = fifo[i][hd[i] % 256];
      req_valid[i]      = en[i] && (hd[i] != tl[i]);
      req_last[i]       = e[9];
      req_rs[i]         = e[8];
      req_data[8*i +: 8] = e[7:0];
    end
  endtask

  task automatic push(input int i, input logic last, input logic rs, input logic [7:0] d);
    fifo[i][tl[i] % 256] = {last, rs, d};
    tl[i]++;
  endtask

  task automatic step();
    logic [N-1:0] exp_rdy, dut_rdy;
    logic idle, exp_en, w_rs, w_last;
    logic [7:0] w_data;
    int w, c, id;
    @(negedge clk);
    idle   = (m_pwr == 0 && m_t == 0);
    exp_en = (m_pwr == 0 && m_t >= TAS + 1 && m_t <= TAS + EN);
    w = -1; exp_rdy = '0; w_rs = 1'b0; w_last = 1'b0; w_data = 8'h00;
    if (idle) begin
      if (m_lock) begin
        if (req_valid[m_gid]) w = m_gid;
      end else begin
        for (int k = 1; k <= N; k++) begin
          c = (m_ptr + k) % N;
          if (w < 0 && req_valid[c]) w = c;
        end
      end
      if (w >= 0) begin
        exp_rdy[w] = 1'b1;
        w_rs = req_rs[w]; w_last = req_last[w]; w_data = req_data[8*w +: 8];
      end
    end
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("lcd_enable", 32'(lcd_enable), 32'(exp_en));
    chk("busy", 32'(busy), 32'(!idle));
    chk("lcd_rs", 32'(lcd_rs), 32'(m_rs));
    chk("lcd_data", 32'(lcd_data), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("lcd_rw", 32'(lcd_rw), 32'(0));
    dut_rdy = req_ready;
    if (req_ready != '0) begin
      id = -1;
      for (int i = N - 1; i >= 0; i--) if (req_ready[i]) id = i;
      acc_cyc.push_back(cyc); acc_id.push_back(id);
    end
    if (prev_acc) dlog.push_back(int'({lcd_rs, lcd_data}));
    prev_acc = (req_ready != '0);
    if (lcd_enable && !prev_en) begin rise_cyc.push_back(cyc); rise_at = cyc; end
    if (!lcd_enable && prev_en) wid_q.push_back(cyc - rise_at);
    prev_en = lcd_enable;
    if (req_ready[0]) rdy0_cnt++;
    @(posedge clk);
    if (!reset) model_reset();
    else if (m_pwr > 0) m_pwr--;
    else if (m_t == 0) begin
      if (w >= 0) begin
        m_t = 1; m_rs = w_rs; m_data = w_data; m_gid = w;
        if (w_last) begin m_lock = 1'b0; m_ptr = w; end
        else m_lock = 1'b1;
      end
    end else begin
      m_t++;
      if (m_t > TAS + EN + TH + wait_len(m_rs, m_data)) m_t = 0;
    end
    for (int i = 0; i < N; i++) if (dut_rdy[i]) hd[i]++;
    cyc++;
    #1 drive_inputs();
  endtask

  task automatic run_until_acc(input int n, input int budget);
    int target;
    target = acc_cyc.size() + n;
    while (acc_cyc.size() < target && budget > 0) begin step(); budget--; end
    if (acc_cyc.size() < target) begin
      checks++; errors++;
      $display("FAIL acceptance timeout: got %0d acceptances expected %0d", acc_cyc.size(), target);
    end
  endtask

  task automatic drain();
    int bud;
    bud = 6000;
    while (bud > 0 && !(all_empty() && m_pwr == 0 && m_t == 0)) begin step(); bud--; end
    chk("drain done", 32'(all_empty() && m_pwr == 0 && m_t == 0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bl;
    reset = 1'b0;
    req_valid = '0; req_rs = '0; req_last = '0; req_data = '0;
    en = '1; rdy0_cnt = 0; rise_at = 0; prev_en = 1'b0;
    for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; end
    model_reset();
    clear_logs();

    // reset release with all requesters valid: two single-byte bursts each
    for (int i = 0; i < N; i++)
      for (int j = 0; j < 2; j++) push(i, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    drive_inputs();
    step(); step();
    reset = 1'b1; cyc = 0; clear_logs();
    run_until_acc(6, 400);
    chk("first accept cycle", 32'(qget(acc_cyc, 0)), 32'(10));
    chk("first grant id", 32'(qget(acc_id, 0)), 32'(0));
    chk("enable rise cycle", 32'(qget(rise_cyc, 0)), 32'(13));
    chk("enable width", 32'(qget(wid_q, 0)), 32'(4));
    chk("rr order 1", 32'(qget(acc_id, 1)), 32'(1));
    chk("rr order 2", 32'(qget(acc_id, 2)), 32'(2));
    chk("rr order 3", 32'(qget(acc_id, 3)), 32'(0));
    chk("rr order 4", 32'(qget(acc_id, 4)), 32'(1));
    chk("rr order 5", 32'(qget(acc_id, 5)), 32'(2));
    chk("short byte period", 32'(qget(acc_cyc, 1) - qget(acc_cyc, 0)), 32'(17));

    // locked burst from requester 1 with requester 2 pending
    clear_logs();
    push(1, 1'b0, 1'b0, 8'h40); push(1, 1'b0, 1'b1, 8'h1F); push(1, 1'b1, 1'b1, 8'h0E);
    push(2, 1'b1, 1'b1, 8'h55);
    drive_inputs();
    run_until_acc(4, 400);
    chk("burst grant 0", 32'(qget(acc_id, 0)), 32'(1));
    chk("burst grant 1", 32'(qget(acc_id, 1)), 32'(1));
    chk("burst grant 2", 32'(qget(acc_id, 2)), 32'(1));
    chk("burst grant 3", 32'(qget(acc_id, 3)), 32'(2));
    chk("burst byte 0", 32'(qget(dlog, 0)), 32'h040);
    chk("burst byte 1", 32'(qget(dlog, 1)), 32'h11F);
    chk("burst byte 2", 32'(qget(dlog, 2)), 32'h10E);

    // long vs short execution wait
    clear_logs();
    push(0, 1'b1, 1'b0, 8'h01); push(0, 1'b1, 1'b1, 8'h01); push(0, 1'b1, 1'b1, 8'h20);
    drive_inputs();
    run_until_acc(3, 400);
    chk("clear-display period", 32'(qget(acc_cyc, 1) - qget(acc_cyc, 0)), 32'(39));
    chk("data 0x01 period", 32'(qget(acc_cyc, 2) - qget(acc_cyc, 1)), 32'(17));

    // randomized bursts across all requesters
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (tl[i] - hd[i] < 2 && $urandom_range(0, 3) == 0) begin
          bl = $urandom_range(1, 3);
          for (int b = 0; b < bl; b++)
            push(i, b == bl - 1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255)));
        end
      end
      drive_inputs();
      step();
    end
    drain();

    // locked requester drops valid mid-burst
    clear_logs();
    push(2, 1'b0, 1'b1, 8'hA1); push(2, 1'b0, 1'b1, 8'hA2); push(2, 1'b1, 1'b1, 8'hA3);
    drive_inputs();
    run_until_acc(1, 200);
    en[2] = 1'b0;
    push(0, 1'b1, 1'b1, 8'h77);
    drive_inputs();
    rdy0_cnt = 0;
    for (int n = 0; n < 50; n++) step();
    chk("starved ready0 count", 32'(rdy0_cnt), 32'(0));
    en[2] = 1'b1;
    drive_inputs();
    run_until_acc(3, 400);
    chk("resume grant 0", 32'(qget(acc_id, 1)), 32'(2));
    chk("resume grant 1", 32'(qget(acc_id, 2)), 32'(2));
    chk("resume grant 2", 32'(qget(acc_id, 3)), 32'(0));
    drain();

    // asynchronous reset in the middle of the enable pulse
    push(1, 1'b1, 1'b1, 8'h3C);
    drive_inputs();
    bl = 200;
    while (!(m_pwr == 0 && m_t == TAS + 2) && bl > 0) begin step(); bl--; end
    chk("pre-reset enable", 32'(lcd_enable), 32'(1));
    reset = 1'b0;
    model_reset();
    #1;
    chk("async enable", 32'(lcd_enable), 32'(0));
    chk("async busy", 32'(busy), 32'(1));
    chk("async data", 32'(lcd_data), 32'(0));
    chk("async rs", 32'(lcd_rs), 32'(0));
    chk("async ready", 32'(req_ready), 32'(0));
    for (int i = 0; i < N; i++) push(i, 1'b1, 1'b1, 8'($urandom_range(0, 255)));
    drive_inputs();
    step(); step();
    reset = 1'b1; cyc = 0; clear_logs();
    run_until_acc(1, 200);
    chk("post-reset accept cycle", 32'(qget(acc_cyc, 0)), 32'(10));
    chk("post-reset grant id", 32'(qget(acc_id, 0)), 32'(0));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
